// File: rtl/mem_pkg.sv
// Shared memory-path encodings, MMIO addresses and fill constants (load and store paths).
package mem_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned WADDR_W          = 15;
    localparam int unsigned READ_LATENCY_DEF = 1;

    typedef enum logic [1:0] {
        MEM_DISABLE   = 2'b00,
        MEM_READ_SEXT = 2'b01,
        MEM_READ_ZEXT = 2'b10,
        MEM_WRITE     = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        BYTE     = 2'b00,
        HALFWORD = 2'b01,
        WORD     = 2'b10
    } mem_size_e;

    localparam logic [WADDR_W-1:0] MMIO_IN_WADDR  = 15'h3FE;
    localparam logic [WADDR_W-1:0] MMIO_OUT_WADDR = 15'h3FF;

    localparam logic [DATA_W-1:0] MISALIGN_FILL = 32'hCAFE_BABE;
    localparam logic [DATA_W-1:0] UNMAPPED_FILL = 32'hDEAD_BEEF;

    // Per-request metadata carried alongside the BRAM read latency
    typedef struct packed {
        logic       valid;
        logic       sext;
        logic [1:0] size;
        logic [1:0] off;
        logic       is_mmio;
        logic       misal;
    } load_meta_t;

    // Size/offset combinations the lane layout cannot serve; size 2'b11 is never legal
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        case (size)
            BYTE:     res = 1'b0;
            HALFWORD: res = off[0];
            WORD:     res = (off != 2'b00);
            default:  res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational lane extraction and sign/zero extension of one load result.
module load_formatter
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] src_i,
    input  logic              from_mmio_i,
    input  logic [1:0]        size_i,
    input  logic [1:0]        off_i,
    input  logic              sext_i,
    output logic [DATA_W-1:0] result_c_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] word_c;

    // BRAM lanes are byte-reversed relative to CPU order; the MMIO word is already native
    always_comb begin
        byte_c = 8'h00;
        half_c = 16'h0000;
        word_c = 32'h0000_0000;
        case (off_i)
            2'd0:    byte_c = src_i[7:0];
            2'd1:    byte_c = src_i[15:8];
            2'd2:    byte_c = src_i[23:16];
            default: byte_c = src_i[31:24];
        endcase
        if (from_mmio_i) begin
            half_c = off_i[1] ? src_i[31:16] : src_i[15:0];
            word_c = src_i;
        end else begin
            half_c = off_i[1] ? {src_i[23:16], src_i[31:24]} : {src_i[7:0], src_i[15:8]};
            word_c = {src_i[7:0], src_i[15:8], src_i[23:16], src_i[31:24]};
        end
    end

    // Extend the extracted field to a full word
    always_comb begin
        result_c_o = word_c;
        case (size_i)
            BYTE:     result_c_o = {{24{sext_i & byte_c[7]}}, byte_c};
            HALFWORD: result_c_o = {{16{sext_i & half_c[15]}}, half_c};
            default:  result_c_o = word_c;
        endcase
    end

endmodule

// File: rtl/mem_output_logic.sv
// Load path: tracks reads through BRAM latency, formats the data and registers the result.
module mem_output_logic
    import mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEF  // 1 or 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [1:0]        memOp,
    input  logic [1:0]        memSize,
    input  logic [31:0]       doutB,
    input  logic [31:0]       edgeIn,
    output logic [31:0]       loadData,
    output logic              loadValid,
    output logic              misaligned,
    output logic [31:0]       edgeSync
);

    load_meta_t        meta_d;
    load_meta_t        stage0_q;
    load_meta_t        meta_last;
    logic [31:0]       sync1_q;
    logic [31:0]       sync2_q;
    logic [31:0]       fmt_c;
    logic [31:0]       load_data_d;
    logic [31:0]       load_data_q;
    logic              load_valid_q;
    logic              misaligned_q;
    logic              unused_addr_c;

    assign unused_addr_c = ^addr[31:17];

    // Capture metadata for an accepted read; writes and idle cycles enter as invalid
    always_comb begin
        meta_d         = '0;
        meta_d.valid   = (memOp == MEM_READ_SEXT) || (memOp == MEM_READ_ZEXT);
        meta_d.sext    = (memOp == MEM_READ_SEXT);
        meta_d.size    = memSize;
        meta_d.off     = addr[1:0];
        meta_d.is_mmio = (addr[16:2] == MMIO_IN_WADDR);
        meta_d.misal   = is_misaligned(memSize, addr[1:0]);
    end

    // First metadata stage; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            stage0_q <= '0;
        end else begin
            stage0_q <= meta_d;
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            load_meta_t stage1_q;

            // Second metadata stage for a two-cycle BRAM
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage1_q <= '0;
                end else begin
                    stage1_q <= stage0_q;
                end
            end

            assign meta_last = stage1_q;
        end else begin : g_lat1
            assign meta_last = stage0_q;
        end
    endgenerate

    // Two-flop synchronizer for the asynchronous external input word
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= edgeIn;
            sync2_q <= sync1_q;
        end
    end

    load_formatter u_formatter (
        .src_i       (meta_last.is_mmio ? sync2_q : doutB),
        .from_mmio_i (meta_last.is_mmio),
        .size_i      (meta_last.size),
        .off_i       (meta_last.off),
        .sext_i      (meta_last.sext),
        .result_c_o  (fmt_c)
    );

    // Next load result: hold unless a request retires; misaligned loads return the fill word
    always_comb begin
        load_data_d = load_data_q;
        if (meta_last.valid) begin
            load_data_d = meta_last.misal ? MISALIGN_FILL : fmt_c;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (reset) begin
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            load_data_q  <= load_data_d;
            load_valid_q <= meta_last.valid;
            misaligned_q <= meta_last.valid & meta_last.misal;
        end
    end

    assign loadData   = load_data_q;
    assign loadValid  = load_valid_q;
    assign misaligned = misaligned_q;
    assign edgeSync   = sync2_q;

endmodule

// File: tb/tb_mem_output_logic.sv
// Self-checking bench for mem_output_logic: directed vectors, hand sequences, random vs. model.
module tb_mem_output_logic;

    localparam int unsigned L  = 1;
    localparam int          RN = 400;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [1:0]  memOp;
    logic [1:0]  memSize;
    logic [31:0] doutB;
    logic [31:0] edgeIn;
    logic [31:0] loadData;
    logic        loadValid;
    logic        misaligned;
    logic [31:0] edgeSync;

    int pass_cnt;
    int total_cnt;

    mem_output_logic #(.READ_LATENCY(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .memOp      (memOp),
        .memSize    (memSize),
        .doutB      (doutB),
        .edgeIn     (edgeIn),
        .loadData   (loadData),
        .loadValid  (loadValid),
        .misaligned (misaligned),
        .edgeSync   (edgeSync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte k of the BRAM word sits at bits 8k; CPU order is most significant lane first
    function automatic logic [31:0] lane(input logic [31:0] w, input int k);
        return (w >> (8 * k)) & 32'hFF;
    endfunction

    function automatic logic ref_misal(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] op, input logic [1:0] size,
                                             input logic [31:0] a, input logic [31:0] bram,
                                             input logic [31:0] ext);
        logic        mmio;
        logic [31:0] src;
        logic [31:0] v;
        int          off;
        int          w;
        mmio = (a[16:2] == 15'h3FE);
        off  = int'(a[1:0]);
        if (ref_misal(size, a)) return 32'hCAFE_BABE;
        src = mmio ? ext : bram;
        if (size == 2'd0) begin
            v = lane(src, off);
            w = 8;
        end else if (size == 2'd1) begin
            v = mmio ? ((src >> (8 * off)) & 32'hFFFF) : ((lane(src, off) << 8) | lane(src, off + 1));
            w = 16;
        end else begin
            v = mmio ? src : ((lane(src, 0) << 24) | (lane(src, 1) << 16) | (lane(src, 2) << 8) | lane(src, 3));
            w = 32;
        end
        if (op == 2'b01 && w < 32 && v[w-1]) v = v | ~((32'd1 << w) - 32'd1);
        return v;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] a;
        logic [31:0] dout;
        logic [31:0] ext;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] tp_word [4];
    logic [31:0] tp_exp  [4];
    logic [31:0] dout_h  [RN+4];
    logic [31:0] edge_h  [RN+4];
    logic [31:0] addr_h  [RN+4];
    logic [1:0]  op_h    [RN+4];
    logic [1:0]  size_h  [RN+4];
    logic [31:0] exp_hold;
    logic [31:0] exp_d;
    logic        exp_v;
    logic        exp_m;
    logic [31:0] av;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0]  = '{2'b01, 2'd2, 32'h10,  32'h7856_3412, 32'h0, 32'h1234_5678, 1'b0};
        vecs[1]  = '{2'b01, 2'd0, 32'h2,   32'h0080_0000, 32'h0, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{2'b10, 2'd0, 32'h2,   32'h0080_0000, 32'h0, 32'h0000_0080, 1'b0};
        vecs[3]  = '{2'b01, 2'd1, 32'h6,   32'h3412_ABCD, 32'h0, 32'h0000_1234, 1'b0};
        vecs[4]  = '{2'b10, 2'd1, 32'h6,   32'h80FF_0000, 32'h0, 32'h0000_FF80, 1'b0};
        vecs[5]  = '{2'b01, 2'd2, 32'h1,   32'h1111_2222, 32'h0, 32'hCAFE_BABE, 1'b1};
        vecs[6]  = '{2'b01, 2'd2, 32'hFF8, 32'h1111_1111, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0};
        vecs[7]  = '{2'b10, 2'd0, 32'hFF8, 32'h2222_2222, 32'hA5A5_0001, 32'h0000_0001, 1'b0};
        vecs[8]  = '{2'b10, 2'd1, 32'h3,   32'h1234_5678, 32'h0, 32'hCAFE_BABE, 1'b1};
        vecs[9]  = '{2'b01, 2'd3, 32'h0,   32'h1234_5678, 32'h0, 32'hCAFE_BABE, 1'b1};
        vecs[10] = '{2'b01, 2'd1, 32'hFFA, 32'h0000_0000, 32'h8001_0000, 32'hFFFF_8001, 1'b0};
        vecs[11] = '{2'b01, 2'd0, 32'h23,  32'h7F00_0000, 32'h0, 32'h0000_007F, 1'b0};
        vecs[12] = '{2'b01, 2'd1, 32'h40,  32'h0000_34F2, 32'h0, 32'hFFFF_F234, 1'b0};

        tp_word[0] = 32'h0403_0201; tp_exp[0] = 32'h0102_0304;
        tp_word[1] = 32'h8877_6655; tp_exp[1] = 32'h5566_7788;
        tp_word[2] = 32'hEFBE_ADDE; tp_exp[2] = 32'hDEAD_BEEF;
        tp_word[3] = 32'h0000_00FF; tp_exp[3] = 32'hFF00_0000;

        // Reset state
        reset   = 1'b1;
        addr    = '0;
        memOp   = 2'b00;
        memSize = 2'd0;
        doutB   = '0;
        edgeIn  = 32'hFFFF_FFFF;
        repeat (3) tick();
        check("reset loadData",   loadData,   32'h0);
        check("reset loadValid",  32'(loadValid),  32'h0);
        check("reset misaligned", 32'(misaligned), 32'h0);
        check("reset edgeSync",   edgeSync,   32'h0);

        // Synchronizer depth: two edges from edgeIn to edgeSync
        reset  = 1'b0;
        edgeIn = 32'h1234_5678;
        tick();
        check("sync after 1 edge", edgeSync, 32'h0);
        tick();
        check("sync after 2 edges", edgeSync, 32'h1234_5678);

        // Directed vectors, one isolated request each
        for (int i = 0; i < 13; i++) begin
            edgeIn = vecs[i].ext;
            memOp  = 2'b00;
            repeat (3) tick();
            memOp   = vecs[i].op;
            memSize = vecs[i].size;
            addr    = vecs[i].a;
            doutB   = vecs[i].dout;
            tick();
            memOp = 2'b00;
            addr  = 32'h0;
            for (int k = 1; k < int'(L); k++) tick();
            tick();
            check($sformatf("vec%0d loadValid", i), 32'(loadValid), 32'h1);
            check($sformatf("vec%0d loadData", i), loadData, vecs[i].exp_data);
            check($sformatf("vec%0d misaligned", i), 32'(misaligned), 32'(vecs[i].exp_mis));
            tick();
            check($sformatf("vec%0d pulse end valid", i), 32'(loadValid), 32'h0);
            check($sformatf("vec%0d pulse end misal", i), 32'(misaligned), 32'h0);
            check($sformatf("vec%0d hold", i), loadData, vecs[i].exp_data);
        end

        // Back-to-back word loads: one result per cycle, in order
        for (int j = 0; j < 4 + int'(L); j++) begin
            memOp   = (j < 4) ? 2'b01 : 2'b00;
            memSize = 2'd2;
            addr    = 32'(32'h20 + 4 * j);
            doutB   = (j >= int'(L) && j - int'(L) < 4) ? tp_word[j - int'(L)] : 32'h0;
            tick();
            if (j >= int'(L)) begin
                check($sformatf("b2b%0d loadValid", j - int'(L)), 32'(loadValid), 32'h1);
                check($sformatf("b2b%0d loadData", j - int'(L)), loadData, tp_exp[j - int'(L)]);
            end
        end
        memOp = 2'b00;
        tick();
        check("b2b drained", 32'(loadValid), 32'h0);

        // Reset in flight: two loads, reset the following cycle (with a request during reset)
        for (int j = 0; j < 7; j++) begin
            reset   = (j == 2);
            memOp   = (j <= 2) ? 2'b01 : 2'b00;
            memSize = 2'd2;
            addr    = 32'h30;
            doutB   = 32'h5555_AAAA;
            tick();
            if (j >= 2) begin
                check($sformatf("rst cyc%0d loadValid", j), 32'(loadValid), 32'h0);
                check($sformatf("rst cyc%0d loadData", j), loadData, 32'h0);
            end
        end
        reset = 1'b0;

        // Random back-to-back traffic against the reference model
        exp_hold = 32'h0;
        for (int k = 0; k < RN + int'(L); k++) begin
            av = $urandom;
            if ($urandom_range(0, 3) == 0) av[16:2] = 15'h3FE;
            op_h[k]   = (k >= 3 && k < RN) ? 2'($urandom_range(0, 3)) : 2'b00;
            size_h[k] = 2'($urandom_range(0, 3));
            addr_h[k] = av;
            dout_h[k] = $urandom;
            edge_h[k] = $urandom;
            memOp   = op_h[k];
            memSize = size_h[k];
            addr    = addr_h[k];
            doutB   = dout_h[k];
            edgeIn  = edge_h[k];
            tick();
            exp_v = 1'b0;
            exp_m = 1'b0;
            exp_d = exp_hold;
            if (k >= int'(L)) begin
                if (op_h[k - int'(L)] == 2'b01 || op_h[k - int'(L)] == 2'b10) begin
                    exp_v = 1'b1;
                    exp_m = ref_misal(size_h[k - int'(L)], addr_h[k - int'(L)]);
                    exp_d = ref_load(op_h[k - int'(L)], size_h[k - int'(L)], addr_h[k - int'(L)],
                                     dout_h[k], edge_h[k - 2 + 0 * int'(L)]);
                end
            end
            exp_hold = exp_d;
            check($sformatf("rand%0d loadValid", k), 32'(loadValid), 32'(exp_v));
            check($sformatf("rand%0d loadData", k), loadData, exp_d);
            check($sformatf("rand%0d misaligned", k), 32'(misaligned), 32'(exp_m));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_output_logic.md
Name: mem_output_logic

Overview:
- Load-path counterpart of the store-path byte-lane steering block; sits between BRAM port B read data and the CPU writeback stage.
- Tracks each read request through the BRAM read latency.
- Extracts the addressed byte, halfword or word from the little-endian lane layout the store path writes, then sign- or zero-extends it.
- Substitutes a synchronized external input word when the MMIO input address is read, and flags misaligned loads.

Parameters:
- MEM_DISABLE, 2'b00, memOp: no access
- MEM_READ_SEXT, 2'b01, memOp: sign-extending load
- MEM_READ_ZEXT, 2'b10, memOp: zero-extending load
- MEM_WRITE, 2'b11, memOp: store (ignored by this block)
- BYTE, 2'b00, memSize byte
- HALFWORD, 2'b01, memSize halfword
- WORD, 2'b10, memSize word
- READ_LATENCY, 1, BRAM port B read latency in cycles (legal values: 1 or 2)
- MMIO_IN_WADDR, 15'h3FE, word address (addr[16:2]) of the external-input register
- MISALIGN_FILL, 32'hCAFE_BABE, loadData value returned on a misaligned load

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  32  byte address of the request (same cycle as memOp)
- memOp  in  2  operation code
- memSize  in  2  access size
- doutB  in  32  BRAM port B read data, valid READ_LATENCY cycles after the request
- edgeIn  in  32  asynchronous external input word
- loadData  out  32  formatted load result, CPU-native order (MSB = bit 31)
- loadValid  out  1  one-cycle pulse; loadData holds a new result
- misaligned  out  1  one-cycle pulse, coincident with loadValid, on a misaligned load
- edgeSync  out  32  synchronized edgeIn (debug/visibility)

Behaviour:
- Clocking and reset: one clock domain on clk. reset is synchronous, active-high, sampled on the rising clk edge.
- Reset values:
  - loadData = 0, loadValid = 0, misaligned = 0.
  - All pipeline valid bits = 0.
  - Both synchronizer stages = 0, so edgeSync = 0.
- Request acceptance: a request is accepted in any cycle where memOp is MEM_READ_SEXT or MEM_READ_ZEXT. MEM_WRITE and MEM_DISABLE create no entry.
- Metadata pipeline: depth READ_LATENCY; shifts every cycle and has no stall. Each entry holds {valid, sext, size, off = addr[1:0], isMmio = (addr[16:2] == MMIO_IN_WADDR), misal}.
- misal rule:
  - HALFWORD with addr[0] = 1, or WORD with addr[1:0] != 0.
  - memSize = 2'b11 is treated as misaligned.
- Format stage: combinational on the last pipeline entry and doutB. Source word src = isMmio ? edgeSync : doutB.
- Lane extraction from BRAM (inverse of the store path; m = doutB):
  - WORD: {m[7:0], m[15:8], m[23:16], m[31:24]}
  - HALFWORD off 0: {m[7:0], m[15:8]}
  - HALFWORD off 2: {m[23:16], m[31:24]}
  - BYTE off k: m[8k+7:8k]
- MMIO source: no byte swap. Extraction is native (value bits [8k+7:8k] for byte k, [16h+15:16h] for halfword h), then the same extension rules apply.
- Extension: sext fills the upper bits with the extracted MSB; otherwise zeros.
- Output register: result registered into loadData. Total latency request→loadValid = READ_LATENCY + 1 cycles.
  - loadValid = last-entry valid.
  - misaligned = valid & misal.
  - Misaligned result: loadData = MISALIGN_FILL.
- Hold rules: loadData holds its last value when no result is retiring. Back-to-back requests every cycle give a loadValid every cycle, with no bubbles.
- Synchronizer: 2-flop synchronizer on edgeIn (sync1 <= edgeIn, sync2 <= sync1; edgeSync = sync2). The MMIO read returns sync2 as sampled in the format cycle.
- Reset mid-operation: all in-flight entries are discarded; no loadValid for a request issued before or during reset.
- Simultaneous events: a new request in the same cycle a result retires is accepted normally. A write in a read's shadow does not affect the read's metadata.

Decomposition:
- Shared package (mem_pkg): memOp and memSize encodings, MMIO word addresses (3FE input, 3FF output), fill constants (CAFE_BABE, DEADBEEF). The store-path block also uses this package.
- One natural sub-module: load_formatter (purely combinational extraction + extension). The pipeline, synchronizer and output register stay in the top.

Test Plan:
1. Word load: doutB = 32'h78563412, LW at addr 0x10, sext → loadValid at request + 2 cycles (READ_LATENCY = 1), loadData = 32'h12345678, misaligned = 0.
2. Byte sign/zero extension: doutB = 32'h00800000, LB at addr 0x2 → loadData = 32'hFFFFFF80; the same access with LBU → 32'h00000080.
3. Halfword off 2: doutB = 32'h3412ABCD, LH at addr 0x6 → 32'h00001234; doutB = 32'h80FF0000, LHU at addr 0x6 → 32'h0000FF80.
4. Misaligned: LW at addr 0x1 → loadData = 32'hCAFEBABE, misaligned = 1 for exactly one cycle, coincident with loadValid.
5. MMIO read: edgeIn = 32'hA5A5_0001 held ≥ 3 cycles, LW at addr 0x0000_0FF8 → loadData = 32'hA5A50001 (no swap); LBU at addr 0xFF8 → 32'h00000001.
6. Throughput and reset: four back-to-back LWs → four consecutive loadValid pulses in order. Assert reset in the cycle after the second request → no further loadValid; loadData = 0 the cycle after reset.
